// File: rtl/lc4_mem_stage_sb.sv
// LC4 memory stage with a store buffer, store-to-load forwarding and a
// handshaked, variable-latency data-memory port.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | accepting ops; drains buffered stores when idle
// LD_REQ  | load miss request presented, waiting for dmem_gnt
// LD_WAIT | load miss granted, waiting for dmem_rvalid
module lc4_mem_stage_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [2:0]        in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_rd,
    output logic              out_we,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];
    logic [PTR_W-1:0]  sb_head, sb_tail;
    logic [CNT_W-1:0]  sb_count;
    logic              sb_full;

    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_rd;
    logic              ld_we;

    logic              slot_free, accept, acc_load, acc_store, ld_miss;
    logic              drain, push, pop;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign slot_free = !out_valid || out_ready;
    assign sb_full   = (sb_count == CNT_W'(SB_DEPTH));
    assign in_ready  = (state == IDLE) && slot_free && !(in_is_store && sb_full);
    assign accept    = in_valid && in_ready;
    assign acc_load  = accept && in_is_load;
    assign acc_store = accept && in_is_store && !in_is_load;
    assign ld_miss   = acc_load && !fwd_hit;
    // A load accepted this cycle steals the port from any pending drain.
    assign drain     = (state == IDLE) && (sb_count != '0) && !acc_load;
    assign push      = acc_store;
    assign pop       = drain && dmem_gnt;

    // Associative lookup, oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CNT_W'(i) < sb_count) && (sb_addr[sb_head + PTR_W'(i)] == in_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[sb_head + PTR_W'(i)];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and data-memory request decode.
    always_comb begin
        state_nxt  = state;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            IDLE: begin
                if (ld_miss) begin
                    state_nxt = LD_REQ;
                end else if (drain) begin
                    dmem_req   = 1'b1;
                    dmem_we    = 1'b1;
                    dmem_addr  = sb_addr[sb_head];
                    dmem_wdata = sb_data[sb_head];
                end
            end
            LD_REQ: begin
                dmem_req  = 1'b1;
                dmem_addr = ld_addr;
                if (dmem_gnt) state_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                if (dmem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store-buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_head  <= '0;
            sb_tail  <= '0;
            sb_count <= '0;
        end else begin
            if (push) sb_tail <= sb_tail + 1'b1;
            if (pop)  sb_head <= sb_head + 1'b1;
            case ({push, pop})
                2'b10:   sb_count <= sb_count + 1'b1;
                2'b01:   sb_count <= sb_count - 1'b1;
                default: sb_count <= sb_count;
            endcase
        end
    end

    // Store-buffer payload; stale entries are simply ignored after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[sb_tail] <= in_addr;
            sb_data[sb_tail] <= in_wdata;
        end
    end

    // Result register toward writeback and the outstanding-miss context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            ld_addr   <= '0;
            ld_rd     <= '0;
            ld_we     <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && !ld_miss) begin
                out_valid <= 1'b1;
                out_data  <= acc_load ? fwd_data : DATA_W'(in_addr);
                out_rd    <= in_rd;
                out_we    <= acc_store ? 1'b0 : in_we;
            end
            if (ld_miss) begin
                ld_addr <= in_addr;
                ld_rd   <= in_rd;
                ld_we   <= in_we;
            end
            if ((state == LD_WAIT) && dmem_rvalid) begin
                out_valid <= 1'b1;
                out_data  <= dmem_rdata;
                out_rd    <= ld_rd;
                out_we    <= ld_we;
            end
        end
    end
endmodule
